// File: rtl/sm83_dbg_uart_pkg.sv
// Shared types and constants for the sm83 debug UART link layer.
package sm83_dbg_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int DATA_BITS   = 8;
  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sm83_dbg_uart_chk.sv
// Parameter sanity and handshake invariants for sm83_dbg_uart.
module sm83_dbg_uart_chk #(
  parameter int CLKS_PER_BIT = 16,
  parameter int RX_DEPTH     = 4
) (
  input logic       clk,
  input logic       reset,
  input logic [7:0] data_rx,
  input logic       data_rx_valid,
  input logic       rx_overrun,
  input logic       rx_frame_err
);

  a_clks_per_bit: assert property (@(posedge clk) CLKS_PER_BIT >= 4);

  a_rx_depth: assert property (@(posedge clk)
    (RX_DEPTH >= 2) && ((RX_DEPTH & (RX_DEPTH - 1)) == 0));

  a_pulse_excl: assert property (@(posedge clk) disable iff (reset)
    !(rx_overrun && rx_frame_err));

  a_rx_hold: assert property (@(posedge clk) disable iff (reset)
    (data_rx_valid && $past(data_rx_valid)) |-> $stable(data_rx));

endmodule

// File: rtl/sm83_dbg_uart_fifo.sv
// Small show-ahead FIFO buffering received bytes until the debug interface takes them.
module sm83_dbg_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_wr_s;
  logic             do_rd_s;

  // Full is judged on the count before any pop in the same cycle.
  assign empty   = (count_r == CNT_ZERO);
  assign full    = (count_r == CNT_FULL);
  assign do_wr_s = wr_en && !full;
  assign do_rd_s = rd_en && !empty;
  assign rd_data = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (do_wr_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_wr_s, do_rd_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/sm83_dbg_uart.sv
// 8N1 serial link for the sm83 debug interface: UART RX into a toggle-handshake
// offer port via a small FIFO, and a toggle-handshake request port out to UART TX.
module sm83_dbg_uart
  import sm83_dbg_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int RX_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [7:0] data_rx,
  output logic       data_rx_valid,
  output logic       data_rx_seq,
  input  logic       data_rx_ack,
  input  logic [7:0] data_tx,
  input  logic       data_tx_seq,
  output logic       data_tx_ack,
  output logic       rx_overrun,
  output logic       rx_frame_err
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [BW-1:0] BIT_ZERO = {BW{1'b0}};
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] rx_sync_r;
  logic                   rx_s;
  uart_state_t            rx_state_r;
  logic [CW-1:0]          rx_cnt_r;
  logic [BW-1:0]          rx_bit_r;
  logic [DATA_BITS-1:0]   rx_shift_r;
  logic                   rx_overrun_r;
  logic                   rx_frame_err_r;
  logic                   stop_hit_s;

  logic                   fifo_wr_s;
  logic                   fifo_rd_s;
  logic                   fifo_empty_s;
  logic                   fifo_full_s;
  logic [DATA_BITS-1:0]   fifo_rd_data_s;

  logic [DATA_BITS-1:0]   data_rx_r;
  logic                   data_rx_seq_r;
  logic                   pending_s;

  uart_state_t            tx_state_r;
  logic [CW-1:0]          tx_cnt_r;
  logic [BW-1:0]          tx_bit_r;
  logic [DATA_BITS-1:0]   tx_shift_r;
  logic                   tx_seq_r;
  logic                   uart_tx_r;
  logic                   data_tx_ack_r;

  assign rx_s       = rx_sync_r[SYNC_STAGES-1];
  assign stop_hit_s = (rx_state_r == STOP) && (rx_cnt_r == CNT_ZERO);
  assign fifo_wr_s  = stop_hit_s && rx_s && !fifo_full_s;
  assign pending_s  = (data_rx_seq_r != data_rx_ack);
  assign fifo_rd_s  = !pending_s && !fifo_empty_s;

  assign uart_tx       = uart_tx_r;
  assign data_rx       = data_rx_r;
  assign data_rx_valid = pending_s;
  assign data_rx_seq   = data_rx_seq_r;
  assign data_tx_ack   = data_tx_ack_r;
  assign rx_overrun    = rx_overrun_r;
  assign rx_frame_err  = rx_frame_err_r;

  sm83_dbg_uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (fifo_wr_s),
    .wr_data (rx_shift_r),
    .rd_en   (fifo_rd_s),
    .rd_data (fifo_rd_data_s),
    .empty   (fifo_empty_s),
    .full    (fifo_full_s)
  );

  sm83_dbg_uart_chk #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .RX_DEPTH     (RX_DEPTH)
  ) u_chk (
    .clk           (clk),
    .reset         (reset),
    .data_rx       (data_rx),
    .data_rx_valid (data_rx_valid),
    .rx_overrun    (rx_overrun),
    .rx_frame_err  (rx_frame_err)
  );

  // Input synchroniser and RX deserialiser; start is re-checked mid-bit to reject glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync_r      <= {SYNC_STAGES{1'b1}};
      rx_state_r     <= IDLE;
      rx_cnt_r       <= CNT_ZERO;
      rx_bit_r       <= BIT_ZERO;
      rx_shift_r     <= {DATA_BITS{1'b0}};
      rx_overrun_r   <= 1'b0;
      rx_frame_err_r <= 1'b0;
    end else begin
      rx_sync_r      <= {rx_sync_r[SYNC_STAGES-2:0], uart_rx};
      rx_overrun_r   <= 1'b0;
      rx_frame_err_r <= 1'b0;
      case (rx_state_r)
        IDLE: begin
          if (!rx_s) begin
            rx_state_r <= START;
            rx_cnt_r   <= HALF_M1;
          end
        end
        START: begin
          if (rx_cnt_r != CNT_ZERO) begin
            rx_cnt_r <= rx_cnt_r - CNT_ONE;
          end else if (rx_s) begin
            rx_state_r <= IDLE;
          end else begin
            rx_state_r <= DATA;
            rx_cnt_r   <= FULL_M1;
            rx_bit_r   <= BIT_ZERO;
          end
        end
        DATA: begin
          if (rx_cnt_r != CNT_ZERO) begin
            rx_cnt_r <= rx_cnt_r - CNT_ONE;
          end else begin
            rx_shift_r <= {rx_s, rx_shift_r[DATA_BITS-1:1]};
            rx_cnt_r   <= FULL_M1;
            if (rx_bit_r == LAST_BIT) begin
              rx_state_r <= STOP;
            end else begin
              rx_bit_r <= rx_bit_r + BIT_ONE;
            end
          end
        end
        STOP: begin
          if (rx_cnt_r != CNT_ZERO) begin
            rx_cnt_r <= rx_cnt_r - CNT_ONE;
          end else begin
            rx_state_r     <= IDLE;
            rx_overrun_r   <= rx_s && fifo_full_s;
            rx_frame_err_r <= !rx_s;
          end
        end
        default: rx_state_r <= IDLE;
      endcase
    end
  end

  // Offer the FIFO head to the debug interface once the previous byte is acknowledged.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_rx_r     <= {DATA_BITS{1'b0}};
      data_rx_seq_r <= 1'b0;
    end else if (fifo_rd_s) begin
      data_rx_r     <= fifo_rd_data_s;
      data_rx_seq_r <= !data_rx_seq_r;
    end
  end

  // TX serialiser; request inputs are only looked at while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_r    <= IDLE;
      tx_cnt_r      <= CNT_ZERO;
      tx_bit_r      <= BIT_ZERO;
      tx_shift_r    <= {DATA_BITS{1'b0}};
      tx_seq_r      <= 1'b0;
      uart_tx_r     <= 1'b1;
      data_tx_ack_r <= 1'b0;
    end else begin
      case (tx_state_r)
        IDLE: begin
          if (data_tx_seq != data_tx_ack_r) begin
            tx_shift_r <= data_tx;
            tx_seq_r   <= data_tx_seq;
            uart_tx_r  <= 1'b0;
            tx_cnt_r   <= FULL_M1;
            tx_state_r <= START;
          end
        end
        START: begin
          if (tx_cnt_r != CNT_ZERO) begin
            tx_cnt_r <= tx_cnt_r - CNT_ONE;
          end else begin
            uart_tx_r  <= tx_shift_r[0];
            tx_shift_r <= {1'b0, tx_shift_r[DATA_BITS-1:1]};
            tx_cnt_r   <= FULL_M1;
            tx_bit_r   <= BIT_ZERO;
            tx_state_r <= DATA;
          end
        end
        DATA: begin
          if (tx_cnt_r != CNT_ZERO) begin
            tx_cnt_r <= tx_cnt_r - CNT_ONE;
          end else begin
            tx_cnt_r <= FULL_M1;
            if (tx_bit_r == LAST_BIT) begin
              uart_tx_r  <= 1'b1;
              tx_state_r <= STOP;
            end else begin
              uart_tx_r  <= tx_shift_r[0];
              tx_shift_r <= {1'b0, tx_shift_r[DATA_BITS-1:1]};
              tx_bit_r   <= tx_bit_r + BIT_ONE;
            end
          end
        end
        STOP: begin
          if (tx_cnt_r != CNT_ZERO) begin
            tx_cnt_r <= tx_cnt_r - CNT_ONE;
          end else begin
            data_tx_ack_r <= tx_seq_r;
            tx_state_r    <= IDLE;
          end
        end
        default: tx_state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm83_dbg_uart.sv
// Randomised self-checking bench for sm83_dbg_uart against a queue-based link model.
module tb_sm83_dbg_uart;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       uart_rx = 1'b1;
  logic       uart_tx;
  logic [7:0] data_rx;
  logic       data_rx_valid;
  logic       data_rx_seq;
  logic       data_rx_ack = 1'b0;
  logic [7:0] data_tx = 8'h00;
  logic       data_tx_seq = 1'b0;
  logic       data_tx_ack;
  logic       rx_overrun;
  logic       rx_frame_err;

  int checks = 0;
  int errors = 0;
  int ovr_cnt = 0;
  int fe_cnt = 0;
  int exp_ovr = 0;
  int exp_fe = 0;
  logic [7:0] rx_q[$];
  logic rx_seq_m = 1'b0;
  logic tx_seq_m = 1'b0;

  sm83_dbg_uart #(
    .CLKS_PER_BIT (CPB),
    .RX_DEPTH     (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .uart_rx       (uart_rx),
    .uart_tx       (uart_tx),
    .data_rx       (data_rx),
    .data_rx_valid (data_rx_valid),
    .data_rx_seq   (data_rx_seq),
    .data_rx_ack   (data_rx_ack),
    .data_tx       (data_tx),
    .data_tx_seq   (data_tx_seq),
    .data_tx_ack   (data_tx_ack),
    .rx_overrun    (rx_overrun),
    .rx_frame_err  (rx_frame_err)
  );

  always #5 clk = ~clk;

  // Count cycles on which each error pulse is high.
  always @(negedge clk) begin
    if (rx_overrun) ovr_cnt <= ovr_cnt + 1;
    if (rx_frame_err) fe_cnt <= fe_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive the first nbits of an 8N1 frame; a complete frame updates the model.
  task automatic rx_frame(input logic [7:0] b, input logic stop, input int nbits);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      uart_rx = fr[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    uart_rx = 1'b1;
    if (nbits == 10) begin
      if (!stop) exp_fe++;
      else if (rx_q.size() < DEPTH + 1) rx_q.push_back(b);
      else exp_ovr++;
    end
  endtask

  // Wait for the next modelled byte, check it, then acknowledge it.
  task automatic expect_rx();
    logic [7:0] e;
    int n;
    e = rx_q.pop_front();
    rx_seq_m = ~rx_seq_m;
    n = 0;
    @(negedge clk);
    while (!data_rx_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq("rx_valid", data_rx_valid, 1'b1);
    check_eq("rx_data", data_rx, e);
    check_eq("rx_seq", data_rx_seq, rx_seq_m);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    check_eq("rx_hold", data_rx, e);
    @(posedge clk);
    #1 data_rx_ack = rx_seq_m;
    #1 check_eq("rx_ack_clears_valid", data_rx_valid, 1'b0);
  endtask

  // Request a transmission and check the line cycle by cycle plus the ack timing.
  task automatic tx_xfer(input logic [7:0] b);
    logic [9:0] fr;
    logic old;
    int n;
    fr = {1'b1, b, 1'b0};
    old = tx_seq_m;
    tx_seq_m = ~tx_seq_m;
    @(posedge clk);
    #1;
    data_tx = b;
    data_tx_seq = tx_seq_m;
    @(negedge clk);
    n = 0;
    while (uart_tx !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 8) data_tx = ~b;
      check_eq("tx_bit", uart_tx, fr[i/4]);
      if (i == 39) check_eq("tx_ack_early", data_tx_ack, old);
    end
    @(negedge clk);
    check_eq("tx_ack", data_tx_ack, tx_seq_m);
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_uart_tx", uart_tx, 1'b1);
    check_eq("rst_valid", data_rx_valid, 1'b0);
    check_eq("rst_seq", data_rx_seq, 1'b0);
    check_eq("rst_tx_ack", data_tx_ack, 1'b0);
    check_eq("rst_data_rx", data_rx, 8'h00);
    check_eq("rst_pulses", {rx_overrun, rx_frame_err}, 2'b00);

    @(posedge clk);
    #1 rx_frame(8'hA5, 1'b1, 10);
    expect_rx();

    for (int i = 1; i <= 6; i++) rx_frame(8'(i), 1'b1, 10);
    repeat (4) @(negedge clk);
    check_eq("burst_overrun", ovr_cnt, exp_ovr);
    while (rx_q.size() > 0) expect_rx();

    for (int t = 0; t < 5; t++) begin
      k = $urandom_range(1, 7);
      @(posedge clk);
      #1;
      for (int j = 0; j < k; j++) rx_frame(8'($urandom), 1'b1, 10);
      repeat (4) @(negedge clk);
      check_eq("rnd_overrun", ovr_cnt, exp_ovr);
      while (rx_q.size() > 0) expect_rx();
      repeat (3) @(negedge clk);
      check_eq("rnd_drained", data_rx_valid, 1'b0);
    end

    @(posedge clk);
    #1 rx_frame(8'h3C, 1'b0, 10);
    repeat (20) @(negedge clk);
    check_eq("frame_err", fe_cnt, exp_fe);
    check_eq("frame_seq", data_rx_seq, rx_seq_m);
    check_eq("frame_valid", data_rx_valid, 1'b0);

    @(posedge clk);
    #1 uart_rx = 1'b0;
    @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("glitch_valid", data_rx_valid, 1'b0);
    check_eq("glitch_seq", data_rx_seq, rx_seq_m);
    check_eq("glitch_pulses", ovr_cnt + fe_cnt, exp_ovr + exp_fe);
    @(posedge clk);
    #1 rx_frame(8'($urandom), 1'b1, 10);
    expect_rx();

    tx_xfer(8'h5A);
    for (int t = 0; t < 3; t++) tx_xfer(8'($urandom));

    @(posedge clk);
    #1;
    fork
      tx_xfer(8'hFF);
      rx_frame(8'h00, 1'b1, 10);
    join
    expect_rx();

    @(posedge clk);
    #1;
    data_tx = 8'h00;
    data_tx_seq = ~tx_seq_m;
    rx_frame(8'hFE, 1'b1, 4);
    @(negedge clk);
    check_eq("midrst_tx_busy", uart_tx, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    uart_rx = 1'b1;
    data_tx_seq = 1'b0;
    data_rx_ack = 1'b0;
    rx_seq_m = 1'b0;
    tx_seq_m = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("midrst_tx_high", uart_tx, 1'b1);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (60) @(negedge clk);
    check_eq("midrst_valid", data_rx_valid, 1'b0);
    check_eq("midrst_seq", data_rx_seq, 1'b0);
    check_eq("midrst_data", data_rx, 8'h00);
    check_eq("midrst_tx_ack", data_tx_ack, 1'b0);
    check_eq("midrst_pulses", ovr_cnt + fe_cnt, exp_ovr + exp_fe);

    @(posedge clk);
    #1 rx_frame(8'($urandom), 1'b1, 10);
    expect_rx();
    tx_xfer(8'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
